regfile_rd2w1: RTL and testbench
================================

Name: regfile_rd2w1

Overview:
- 8-entry x 16-bit CPU register file. Read side is the consumer of the write-enabled flip-flop storage used elsewhere in the CPU datapath.
- One synchronous write port and two registered read ports.
- Read ports have a request/valid handshake and write-to-read bypass.
- Sits between instruction decode, which issues reads, and writeback, which issues writes.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers (power of two).
- AW, 3, address width; must equal log2(DEPTH).
- ZERO_R0, 1, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wen  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- rd_req  input  1  read request; samples raddr0/raddr1 this cycle.
- raddr0  input  AW  read address, port 0.
- raddr1  input  AW  read address, port 1.
- rd_stall  input  1  consumer not ready; holds rdata/rvalid.
- rdata0  output  WIDTH  read data, port 0 (registered).
- rdata1  output  WIDTH  read data, port 1 (registered).
- rvalid  output  1  rdata0/rdata1 valid.
- rd_busy  output  1  request this cycle cannot be accepted (rvalid & rd_stall).

Behaviour:
Reset (asynchronous, active-high):
- All DEPTH registers clear to 0.
- rdata0/rdata1 clear to 0; rvalid clears to 0.
- Reset asserted mid-operation discards any in-flight read.
- First edge after deassertion behaves as a normal cycle.

Write:
- On a rising edge with wen=1 and not rst, mem[waddr] <= wdata.
- With ZERO_R0=1 and waddr=0 the write is dropped.
- wen=0 leaves every register unchanged.

Read handshake (two states, EMPTY and HOLD):
- EMPTY (rvalid=0): on rd_req=1, the next edge loads rdata0/rdata1 and sets rvalid=1, moving to HOLD. Latency is 1 cycle.
- HOLD (rvalid=1):
  - rd_stall=1: rdata and rvalid hold, and rd_busy=1. A rd_req in this cycle is not accepted; the requester must hold it.
  - rd_stall=0 and rd_req=1: new data loads on the edge and the block stays in HOLD (back-to-back, one read per cycle).
  - rd_stall=0 and rd_req=0: rvalid clears on the edge and the block returns to EMPTY.
- rd_busy is combinational: rd_busy = rvalid & rd_stall.

Read value (evaluated at the accepting edge):
- If ZERO_R0=1 and raddr=0: 0.
- Else if wen=1 and waddr=raddr (and not a dropped r0 write): wdata. This is the write-before-read bypass.
- Else: mem[raddr].
- Both ports evaluate independently. raddr0=raddr1 is legal, and both then return the same value.

Stalled data:
- While stalled, rdata does not track later writes to the held addresses. It holds the value captured at acceptance.

Out-of-range:
- AW fully decodes DEPTH, so no out-of-range address exists.

Simultaneous events:
- A write and an accepted read in the same cycle to the same address returns the new data (bypass).
- A write to a held address during stall updates mem only; rdata is unaffected.

Test Plan:
1. Reset and write-back read: assert rst asynchronously mid-cycle → rvalid=0 and rdata0=rdata1=0 immediately. Then write r3=16'hBEEF with wen=1; next cycle rd_req with raddr0=3, raddr1=0 → one edge later rvalid=1, rdata0=16'hBEEF, rdata1=0.
2. Bypass: r5 holds 16'h1111; in the same cycle set wen=1, waddr=5, wdata=16'h2222, rd_req=1, raddr0=raddr1=5 → next edge rdata0=rdata1=16'h2222, and mem[5]=16'h2222.
3. R0 discard: write r0=16'hFFFF then read raddr0=0 → rdata0=0. Repeat with the write and read in the same cycle → 0, no bypass.
4. Stall hold: accept a read of r2=16'h00A0, then assert rd_stall for 3 cycles while writing r2=16'h00B0 and asserting rd_req → rdata0 stays 16'h00A0, rvalid=1, rd_busy=1 throughout. Drop rd_stall → next edge rdata0=16'h00B0.
5. Back-to-back: rd_req high for 4 cycles with raddr0=1,2,3,4 and registers holding 10,20,30,40 → rdata0=10,20,30,40 on consecutive cycles with rvalid continuously 1. Drop rd_req → rvalid falls one edge later.
6. Reset mid-read: rd_req accepted, then rst pulsed before the consumer takes the data → rvalid=0 at once, and all registers read 0 afterwards.

Source files
------------

// File: rtl/regfile_rd2w1.sv
// ============================================================================
//  Module   : regfile_rd2w1
//  Purpose  : 8x16 CPU register file, one write port, two registered read
//             ports with request/valid/stall handshake and write bypass.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_rd2w1 #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int ZERO_R0 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_req,
   input  logic [AW-1:0]    raddr0,
   input  logic [AW-1:0]    raddr1,
   input  logic             rd_stall,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1,
   output logic             rvalid,
   output logic             rd_busy
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata0;
   logic [WIDTH-1:0] r_rdata1;

   logic             w_r0_hard;
   logic             w_wr_ok;
   logic [WIDTH-1:0] w_rd0;
   logic [WIDTH-1:0] w_rd1;

   generate
      if (ZERO_R0 != 0) begin : g_r0_hardwired
         assign w_r0_hard = 1'b1;
      end else begin : g_r0_normal
         assign w_r0_hard = 1'b0;
      end
   endgenerate

   assign w_wr_ok = wen & ~(w_r0_hard & (waddr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Read value seen at the accepting edge: hardwired r0, then same-cycle bypass
   always_comb begin
      w_rd0 = r_mem[raddr0];
      w_rd1 = r_mem[raddr1];
      if (w_wr_ok && (waddr == raddr0)) w_rd0 = wdata;
      if (w_wr_ok && (waddr == raddr1)) w_rd1 = wdata;
      if (w_r0_hard && (raddr0 == '0)) w_rd0 = '0;
      if (w_r0_hard && (raddr1 == '0)) w_rd1 = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_EMPTY;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (rd_req) begin
                  r_rdata0 <= w_rd0;
                  r_rdata1 <= w_rd1;
                  r_state  <= S_HOLD;
               end
            end
            S_HOLD: begin
               // Stalled: held data ignores later writes to the same address
               if (!rd_stall) begin
                  if (rd_req) begin
                     r_rdata0 <= w_rd0;
                     r_rdata1 <= w_rd1;
                  end else begin
                     r_state <= S_EMPTY;
                  end
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

   assign rdata0  = r_rdata0;
   assign rdata1  = r_rdata1;
   assign rvalid  = (r_state == S_HOLD);
   assign rd_busy = rvalid & rd_stall;

endmodule

`default_nettype wire

// File: tb/tb_regfile_rd2w1.sv
// ============================================================================
//  Module   : tb_regfile_rd2w1
//  Purpose  : Self-checking bench for regfile_rd2w1 with a read scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_rd2w1;

   logic        clk = 1'b0;
   logic        rst;
   logic        wen;
   logic [2:0]  waddr;
   logic [15:0] wdata;
   logic        rd_req;
   logic [2:0]  raddr0;
   logic [2:0]  raddr1;
   logic        rd_stall;
   logic [15:0] rdata0;
   logic [15:0] rdata1;
   logic        rvalid;
   logic        rd_busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_mem [8];
   logic        m_rvalid;
   logic [15:0] m_rd0;
   logic [15:0] m_rd1;
   logic [31:0] sb[$];

   regfile_rd2w1 #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_R0(1)) dut (
      .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
      .rd_req(rd_req), .raddr0(raddr0), .raddr1(raddr1), .rd_stall(rd_stall),
      .rdata0(rdata0), .rdata1(rdata1), .rvalid(rvalid), .rd_busy(rd_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_rd(input logic [2:0] a, input logic we,
                                          input logic [2:0] wa, input logic [15:0] wd);
      if (a == 3'd0) return 16'h0000;
      if (we && (wa != 3'd0) && (wa == a)) return wd;
      return m_mem[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
      m_rvalid = 1'b0;
      m_rd0    = 16'h0000;
      m_rd1    = 16'h0000;
      sb.delete();
   endtask

   // One clock of stimulus; expected read results go through the scoreboard
   task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic req, input logic [2:0] a0, input logic [2:0] a1,
                       input logic st);
      logic        acc;
      logic [31:0] e;
      wen = we; waddr = wa; wdata = wd;
      rd_req = req; raddr0 = a0; raddr1 = a1; rd_stall = st;
      #1;
      n_tests++;
      if (rd_busy !== (m_rvalid & st)) begin
         n_fail++;
         $display("FAIL rd_busy: got %b want %b", rd_busy, m_rvalid & st);
      end
      acc = req && !(m_rvalid && st);
      if (acc) sb.push_back({exp_rd(a0, we, wa, wd), exp_rd(a1, we, wa, wd)});
      if (we && wa != 3'd0) m_mem[wa] = wd;
      @(posedge clk);
      #1;
      if (acc) begin
         e = sb.pop_front();
         m_rd0 = e[31:16];
         m_rd1 = e[15:0];
         m_rvalid = 1'b1;
      end else if (!(m_rvalid && st)) begin
         m_rvalid = 1'b0;
      end
      n_tests++;
      if (rvalid !== m_rvalid) begin
         n_fail++;
         $display("FAIL rvalid: got %b want %b", rvalid, m_rvalid);
      end
      if (m_rvalid) begin
         n_tests++;
         if (rdata0 !== m_rd0 || rdata1 !== m_rd1) begin
            n_fail++;
            $display("FAIL rdata: got %h/%h want %h/%h", rdata0, rdata1, m_rd0, m_rd1);
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
   endtask

   task automatic mid_cycle_reset(input string name);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (rvalid !== 1'b0 || rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
         n_fail++;
         $display("FAIL %s: got rvalid=%b rdata=%h/%h want 0/0000/0000",
                  name, rvalid, rdata0, rdata1);
      end
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++;
      if (rvalid !== 1'b0 || rdata0 !== 16'h0 || rdata1 !== 16'h0 || rd_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got rvalid=%b rdata=%h/%h busy=%b want 0", rvalid, rdata0, rdata1, rd_busy);
      end
      step(1'b1, 3'd1, 16'h1234, 1'b1, 3'd1, 3'd1, 1'b0);
      mid_cycle_reset("async_reset");
      step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd0, 1'b0);
      n_tests++;
      if (rvalid !== 1'b1 || rdata0 !== 16'hBEEF || rdata1 !== 16'h0000) begin
         n_fail++;
         $display("FAIL write_read: got %b %h %h want 1 beef 0000", rvalid, rdata0, rdata1);
      end
   endtask

   task automatic test_bypass();
      step(1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, 3'd0, 1'b0);
      step(1'b1, 3'd5, 16'h2222, 1'b1, 3'd5, 3'd5, 1'b0);
      n_tests++;
      if (rdata0 !== 16'h2222 || rdata1 !== 16'h2222) begin
         n_fail++;
         $display("FAIL bypass: got %h/%h want 2222/2222", rdata0, rdata1);
      end
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd3, 1'b0);
      n_tests++;
      if (rdata0 !== 16'h2222 || rdata1 !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL bypass_mem: got %h/%h want 2222/beef", rdata0, rdata1);
      end
      idle();
   endtask

   task automatic test_r0();
      step(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd5, 1'b0);
      n_tests++;
      if (rdata0 !== 16'h0000) begin
         n_fail++;
         $display("FAIL r0_read: got %h want 0000", rdata0);
      end
      step(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 1'b0);
      n_tests++;
      if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin
         n_fail++;
         $display("FAIL r0_no_bypass: got %h/%h want 0000/0000", rdata0, rdata1);
      end
      idle();
   endtask

   task automatic test_stall();
      step(1'b1, 3'd2, 16'h00A0, 1'b0, 3'd0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 3'd2, 16'h00B0, 1'b1, 3'd2, 3'd2, 1'b1);
         n_tests++;
         if (rdata0 !== 16'h00A0 || rvalid !== 1'b1 || rd_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: got %h v=%b busy=%b want 00a0 1 1", rdata0, rvalid, rd_busy);
         end
      end
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd0, 1'b0);
      n_tests++;
      if (rdata0 !== 16'h00B0) begin
         n_fail++;
         $display("FAIL stall_release: got %h want 00b0", rdata0);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [15:0] v;
      for (int i = 1; i <= 4; i++) begin
         v = 16'(i * 10);
         step(1'b1, 3'(i), v, 1'b0, 3'd0, 3'd0, 1'b0);
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(5 - i), 1'b0);
         v = 16'(i * 10);
         n_tests++;
         if (rdata0 !== v || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_%0d: got %0d v=%b want %0d 1", i, rdata0, rvalid, v);
         end
      end
      idle();
      n_tests++;
      if (rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drop: got rvalid=%b want 0", rvalid);
      end
   endtask

   task automatic test_reset_mid_read();
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd1, 1'b0);
      rd_stall = 1'b1;
      rd_req   = 1'b0;
      mid_cycle_reset("reset_mid_read");
      for (int i = 0; i < 8; i += 2) begin
         step(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(i + 1), 1'b0);
         n_tests++;
         if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
            n_fail++;
            $display("FAIL cleared_r%0d: got %h/%h want 0000/0000", i, rdata0, rdata1);
         end
      end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0));
      end
      idle();
   endtask

   initial begin
      rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
      rd_req = 1'b0; raddr0 = '0; raddr1 = '0; rd_stall = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_bypass();
      test_r0();
      test_stall();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
